hc_sr_multi_ranger: RTL and testbench

Parametrised multi-channel ultrasonic ranging controller, the successor to the single-sensor HC-SR04 driver. It serves NUM_CH sensors round-robin, one at a time to avoid acoustic crosstalk. For each channel it issues a trigger pulse, times the echo in microseconds, converts the width to millimetres and reports timeouts. It sits between the sensor pins and the display/UART consumers; timing is derived from a single system clock via an internal microsecond tick.

---
 rtl/hc_sr_pkg.sv | 21 ++
 rtl/hc_sr_tick_gen.sv | 29 ++
 rtl/hc_sr_multi_ranger.sv | 215 +++++++++++++++++++++
 tb/tb_hc_sr_multi_ranger.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hc_sr_pkg.sv
// Shared types and constants for the multi-channel HC-SR ultrasonic ranger.
// Holds the FSM state encoding, the us-to-mm scaling constants and the channel-index width helper.
package hc_sr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEAS,
    GAP
  } state_t;

  // 2810 / 2^14 = 0.17151 mm per us of round-trip echo at 343 m/s
  localparam int unsigned MM_PER_US_NUM   = 2810;
  localparam int unsigned MM_PER_US_SHIFT = 14;

  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hc_sr_tick_gen.sv
// Free-running microsecond strobe: one-cycle us_tick every CLK_FREQ_HZ/1e6 clocks, registered output.
// Latency: first tick CLK_FREQ_HZ/1e6 clocks after reset release; no backpressure.
module hc_sr_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic Clk,
  input  logic Rst,
  output logic us_tick
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned DW  = (DIV <= 1) ? 1 : $clog2(DIV);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_cnt <= '0;
      us_tick <= 1'b0;
    end else if (div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
      us_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      us_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/hc_sr_multi_ranger.sv
// Round-robin NUM_CH ultrasonic ranger: trigger, echo timing in us, mm conversion, timeout reporting.
// Result strobes one cycle on GAP entry, echo has 2 cycles sync latency; AVG4_EN adds a per-channel 4-deep mean.
module hc_sr_multi_ranger
  import hc_sr_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned RISE_WAIT_US = 5000,
  parameter int unsigned MAX_ECHO_US  = 30000,
  parameter int unsigned GAP_US       = 10000,
  parameter int unsigned DIST_W       = 16,
  localparam int unsigned CHW         = chw(NUM_CH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trig,
  output logic [DIST_W-1:0] dist_mm,
  output logic [CHW-1:0]    dist_ch,
  output logic              dist_valid,
  output logic              dist_timeout
);

  localparam int unsigned M1      = (TRIG_US > RISE_WAIT_US) ? TRIG_US : RISE_WAIT_US;
  localparam int unsigned M2      = (MAX_ECHO_US > GAP_US) ? MAX_ECHO_US : GAP_US;
  localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [47:0] DIST_MAX = (48'd1 << DIST_W) - 48'd1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  us_cnt, us_cnt_nxt;
  logic [CHW-1:0]    ptr, ptr_nxt;
  logic [NUM_CH-1:0] echo_s1, echo_s2, echo_prev;
  logic              echo_rise, echo_fall;
  logic              us_tick;
  logic              res_load, res_timeout;
  logic [47:0]       prod, quo;
  logic [DIST_W-1:0] raw_mm, res_mm;

  hc_sr_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .Clk     (Clk),
    .Rst     (Rst),
    .us_tick (us_tick)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      echo_s1   <= '0;
      echo_s2   <= '0;
      echo_prev <= '0;
    end else begin
      echo_s1   <= echo;
      echo_s2   <= echo_s1;
      echo_prev <= echo_s2;
    end
  end

  // Per-channel edge history, so an echo already high on WAIT_RISE entry is not a rise
  assign echo_rise = echo_s2[ptr] & ~echo_prev[ptr];
  assign echo_fall = ~echo_s2[ptr] & echo_prev[ptr];

  always_comb begin
    prod   = 48'(us_cnt) * 48'(MM_PER_US_NUM);
    quo    = prod >> MM_PER_US_SHIFT;
    raw_mm = (quo > DIST_MAX) ? '1 : quo[DIST_W-1:0];
  end

  always_comb begin
    trig = '0;
    if (state == TRIG) trig[ptr] = 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    us_cnt_nxt  = us_cnt;
    ptr_nxt     = ptr;
    res_load    = 1'b0;
    res_timeout = 1'b0;
    case (state)
      // Leaving IDLE on a tick keeps the trigger pulse aligned to the us grid
      IDLE: begin
        if (en && us_tick) begin
          state_nxt  = TRIG;
          us_cnt_nxt = '0;
        end
      end
      TRIG: begin
        if (us_tick) begin
          if (us_cnt == CNT_W'(TRIG_US - 1)) begin
            state_nxt  = WAIT_RISE;
            us_cnt_nxt = '0;
          end else begin
            us_cnt_nxt = us_cnt + 1'b1;
          end
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_nxt  = MEAS;
          us_cnt_nxt = '0;
        end else if (us_tick) begin
          if (us_cnt == CNT_W'(RISE_WAIT_US - 1)) begin
            state_nxt   = GAP;
            us_cnt_nxt  = '0;
            res_load    = 1'b1;
            res_timeout = 1'b1;
          end else begin
            us_cnt_nxt = us_cnt + 1'b1;
          end
        end
      end
      // Falling edge wins over the timeout when both land in the same cycle
      MEAS: begin
        if (echo_fall) begin
          state_nxt  = GAP;
          us_cnt_nxt = '0;
          res_load   = 1'b1;
        end else if (us_cnt == CNT_W'(MAX_ECHO_US)) begin
          state_nxt   = GAP;
          us_cnt_nxt  = '0;
          res_load    = 1'b1;
          res_timeout = 1'b1;
        end else if (us_tick) begin
          us_cnt_nxt = us_cnt + 1'b1;
        end
      end
      GAP: begin
        if (us_tick) begin
          if (us_cnt == CNT_W'(GAP_US - 1)) begin
            ptr_nxt    = (ptr == CHW'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
            state_nxt  = en ? TRIG : IDLE;
            us_cnt_nxt = '0;
          end else begin
            us_cnt_nxt = us_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AVG4_EN
  localparam int unsigned SUM_W       = DIST_W + 2;
  localparam int unsigned RECIP_SHIFT = DIST_W + 4;
  // Reciprocals of 1..4 scaled by 2^RECIP_SHIFT; the divide-by-3 entry is rounded up so it stays exact over the sum range
  localparam logic [63:0] RECIP1 = 64'd1 << RECIP_SHIFT;
  localparam logic [63:0] RECIP2 = 64'd1 << (RECIP_SHIFT - 1);
  localparam logic [63:0] RECIP3 = ((64'd1 << RECIP_SHIFT) + 64'd2) / 64'd3;
  localparam logic [63:0] RECIP4 = 64'd1 << (RECIP_SHIFT - 2);

  logic [DIST_W-1:0] hist     [NUM_CH][4];
  logic [2:0]        hist_cnt [NUM_CH];
  logic [1:0]        hist_wr  [NUM_CH];
  logic [SUM_W-1:0]  hist_sum;
  logic [2:0]        fill_nxt;
  logic [63:0]       recip_sel, mean_prod;

  always_comb begin
    hist_sum = SUM_W'(raw_mm);
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != hist_wr[ptr]) hist_sum = hist_sum + SUM_W'(hist[ptr][i]);
    end
    fill_nxt = (hist_cnt[ptr] == 3'd4) ? 3'd4 : hist_cnt[ptr] + 3'd1;
    case (fill_nxt)
      3'd1:    recip_sel = RECIP1;
      3'd2:    recip_sel = RECIP2;
      3'd3:    recip_sel = RECIP3;
      default: recip_sel = RECIP4;
    endcase
    mean_prod = 64'(hist_sum) * recip_sel;
    res_mm    = DIST_W'(mean_prod >> RECIP_SHIFT);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hist_cnt[c] <= '0;
        hist_wr[c]  <= '0;
        for (int j = 0; j < 4; j++) hist[c][j] <= '0;
      end
    end else if (res_load && !res_timeout) begin
      hist[ptr][hist_wr[ptr]] <= raw_mm;
      hist_wr[ptr]            <= hist_wr[ptr] + 2'd1;
      hist_cnt[ptr]           <= fill_nxt;
    end
  end
`else
  assign res_mm = raw_mm;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      us_cnt       <= '0;
      ptr          <= '0;
      dist_mm      <= '0;
      dist_ch      <= '0;
      dist_valid   <= 1'b0;
      dist_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      us_cnt     <= us_cnt_nxt;
      ptr        <= ptr_nxt;
      dist_valid <= res_load;
      if (res_load) begin
        dist_ch      <= ptr;
        dist_timeout <= res_timeout;
        dist_mm      <= res_timeout ? '0 : res_mm;
      end
    end
  end

endmodule

// File: tb/tb_hc_sr_multi_ranger.sv
// Directed bench for hc_sr_multi_ranger: two channels at 2 MHz with shortened windows,
// a table of per-visit echo patterns plus hand-written reset sequences.
module tb_hc_sr_multi_ranger;

  localparam int CLK_FREQ_HZ  = 2_000_000;
  localparam int DIV          = CLK_FREQ_HZ / 1_000_000;
  localparam int NUM_CH       = 2;
  localparam int TRIG_US      = 10;
  localparam int RISE_WAIT_US = 500;
  localparam int MAX_ECHO_US  = 6000;
  localparam int GAP_US       = 200;
  localparam int DIST_W       = 16;

  localparam int M_NONE  = 0;
  localparam int M_PULSE = 1;
  localparam int M_HOLD  = 2;
  localparam int M_STUCK = 3;
  localparam int NVEC    = 9;

`ifdef AVG4_EN
  localparam int EXP_V2 = 749;
  localparam int EXP_V7 = 102;
`else
  localparam int EXP_V2 = 499;
  localparam int EXP_V7 = 34;
`endif

  typedef struct {
    int ch;
    int mode;
    int width_us;
    int exp_to;
    int exp_mm;
  } vec_t;

  logic              Clk;
  logic              Rst;
  logic              en;
  logic [NUM_CH-1:0] echo;
  logic [NUM_CH-1:0] trig;
  logic [DIST_W-1:0] dist_mm;
  logic [0:0]        dist_ch;
  logic              dist_valid;
  logic              dist_timeout;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int bad_onehot = 0;

  vec_t vecs [NVEC];

  hc_sr_multi_ranger #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .NUM_CH       (NUM_CH),
    .TRIG_US      (TRIG_US),
    .RISE_WAIT_US (RISE_WAIT_US),
    .MAX_ECHO_US  (MAX_ECHO_US),
    .GAP_US       (GAP_US),
    .DIST_W       (DIST_W)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .en           (en),
    .echo         (echo),
    .trig         (trig),
    .dist_mm      (dist_mm),
    .dist_ch      (dist_ch),
    .dist_valid   (dist_valid),
    .dist_timeout (dist_timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Rst && dist_valid) n_valid++;
    if ((trig & (trig - 1'b1)) != '0) bad_onehot++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_trig(input int budget, output int n);
    n = 0;
    while (trig == '0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!dist_valid && n < budget) begin
      @(negedge Clk);
      n++;
    end
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {trig, dist_mm, dist_ch, dist_valid, dist_timeout}, 0);
  endtask

  initial begin
    int n;
    int w;
    int ch;
    int saved_valid;

    vecs[0] = '{0, M_PULSE, 5830, 0, 999};
    vecs[1] = '{1, M_NONE,  0,    1, 0};
    vecs[2] = '{0, M_PULSE, 2915, 0, EXP_V2};
    vecs[3] = '{1, M_PULSE, 1000, 0, 171};
    vecs[4] = '{0, M_HOLD,  0,    1, 0};
    vecs[5] = '{1, M_NONE,  0,    1, 0};
    vecs[6] = '{0, M_STUCK, 0,    1, 0};
    vecs[7] = '{1, M_PULSE, 200,  0, EXP_V7};
    vecs[8] = '{0, M_NONE,  0,    1, 0};

    Rst  = 1'b1;
    en   = 1'b1;
    echo = '0;
    repeat (5) @(negedge Clk);
    check_all_zero("reset_state");

    Rst = 1'b0;
    wait_trig(20, n);
    chk("first_trig_latency", n, DIV + 1);

    for (int i = 0; i < NVEC; i++) begin
      ch = vecs[i].ch;
      wait_trig((GAP_US + TRIG_US) * DIV + 100, n);
      chk($sformatf("v%0d trig_sel", i), trig, 1 << ch);
      w = 0;
      while (trig[ch] && w < 200) begin
        @(negedge Clk);
        w++;
      end
      chk($sformatf("v%0d trig_width", i), w, TRIG_US * DIV);

      case (vecs[i].mode)
        M_PULSE: begin
          repeat (3) @(negedge Clk);
          echo[ch] = 1'b1;
          repeat (vecs[i].width_us * DIV) @(negedge Clk);
          echo[ch] = 1'b0;
          wait_valid(50, n);
        end
        M_HOLD: begin
          repeat (3) @(negedge Clk);
          echo[ch] = 1'b1;
          wait_valid(MAX_ECHO_US * DIV + 50, n);
          chk_range($sformatf("v%0d echo_timeout_cycles", i), n,
                    MAX_ECHO_US * DIV + 4, MAX_ECHO_US * DIV + DIV + 3);
        end
        default: wait_valid(RISE_WAIT_US * DIV + 50, n);
      endcase

      chk($sformatf("v%0d dist_valid", i), dist_valid, 1);
      chk($sformatf("v%0d dist_ch", i), dist_ch, ch);
      chk($sformatf("v%0d dist_timeout", i), dist_timeout, vecs[i].exp_to);
      chk($sformatf("v%0d dist_mm", i), dist_mm, vecs[i].exp_mm);
      @(negedge Clk);
      chk($sformatf("v%0d valid_one_cycle", i), dist_valid, 0);
      if (vecs[i].mode == M_STUCK) echo[ch] = 1'b0;
    end

    // Reset while channel 1 is mid-measurement
    wait_trig((GAP_US + TRIG_US) * DIV + 100, n);
    chk("rst_pre trig_sel", trig, 2);
    w = 0;
    while (trig != '0 && w < 200) begin
      @(negedge Clk);
      w++;
    end
    repeat (3) @(negedge Clk);
    echo[1] = 1'b1;
    repeat (200) @(negedge Clk);
    saved_valid = n_valid;
    Rst = 1'b1;
    @(negedge Clk);
    check_all_zero("rst_mid_meas outputs");
    echo[1] = 1'b0;
    Rst = 1'b0;
    wait_trig(20, n);
    chk("rst_restart latency", n, DIV + 1);
    chk("rst_restart trig_sel", trig, 1);
    chk("rst_no_strobe", n_valid, saved_valid);

    chk("total_strobes", n_valid, NVEC);
    chk("trig_onehot_violations", bad_onehot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
